// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and small op-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MUL   = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

  // MUL keeps only the low product, which is identical for signed and
  // unsigned operands, so it runs through the unsigned path.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: radix-2^MUL_BPC shift-add multiply and
// restoring shift-subtract divide, returning the raw {hi,lo} pair.
module muldiv_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] x_mag,
  input  logic [WIDTH-1:0] y_mag,
  output logic [WIDTH-1:0] raw_hi,
  output logic [WIDTH-1:0] raw_lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  // hi_r: product accumulator / partial remainder
  // lo_r: multiplier bits not yet retired / dividend shifting into quotient
  logic [WIDTH-1:0] hi_r, lo_r, opnd_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH+MUL_BPC-1:0] mul_sum;
  logic [WIDTH:0]           shifted;
  logic [WIDTH-1:0]         diff;
  logic                     ge;

  always_comb begin
    mul_sum = {{MUL_BPC{1'b0}}, hi_r}
            + ({{MUL_BPC{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, lo_r[MUL_BPC-1:0]});
    shifted = {hi_r, lo_r[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd_q};
    // Partial remainder stays below the divisor, so the low WIDTH bits of the
    // difference are exact whenever the subtraction is taken.
    diff    = shifted[WIDTH-1:0] - opnd_q;
  end

  // NOTE: no reset on this datapath; every register is loaded on op
  // acceptance before any value is consumed.
  always_ff @(posedge clk) begin
    if (load) begin
      div_q  <= is_div;
      opnd_q <= is_div ? y_mag : x_mag;
      lo_r   <= is_div ? x_mag : y_mag;
      hi_r   <= '0;
      cnt_q  <= is_div ? CW'(WIDTH - 1) : CW'(WIDTH / MUL_BPC - 1);
    end else if (step) begin
      cnt_q <= cnt_q - 1'b1;
      if (div_q) begin
        hi_r <= ge ? diff : shifted[WIDTH-1:0];
        lo_r <= {lo_r[WIDTH-2:0], ge};
      end else begin
        hi_r <= mul_sum[WIDTH+MUL_BPC-1:MUL_BPC];
        lo_r <= {mul_sum[MUL_BPC-1:0], lo_r[WIDTH-1:MUL_BPC]};
      end
    end
  end

  assign raw_hi = hi_r;
  assign raw_lo = lo_r;
  assign last   = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, MTHI/MTLO and cancel.
// Optional MULDIV_DIV0_FLAG_EN adds a div0 flag pulsed with done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  state_e state_q, state_d;
  op_e    op_q;
  logic   neg_q, rem_neg_q, b_zero_q;
  logic [WIDTH-1:0] a_q;

  logic             accept, is_signed, a_neg, b_neg, last, finish;
  logic [WIDTH-1:0] a_mag, b_mag, raw_hi, raw_lo;
  logic [WIDTH-1:0] quo_s, rem_s;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign accept    = (state_q == IDLE) && start && op_is_legal(op) && !cancel;
  assign is_signed = op_is_signed(op_e'(op));
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign finish    = (state_q == FIX) && !cancel;

  muldiv_iter #(
    .WIDTH  (WIDTH),
    .MUL_BPC(MUL_BPC)
  ) u_iter (
    .clk   (clk),
    .load  (accept),
    .step  (state_q == CALC),
    .is_div(op_is_div(op_e'(op))),
    .x_mag (a_mag),
    .y_mag (b_mag),
    .raw_hi(raw_hi),
    .raw_lo(raw_lo),
    .last  (last)
  );

  // NOTE: the combinational process assigns every output a default first so
  // that no path leaves a value held, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cancel) state_d = IDLE;
               else if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign fixup: product/quotient sign is the XOR of operand signs, the
  // remainder follows the dividend.
  always_comb begin
    prod   = {raw_hi, raw_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -raw_lo : raw_lo;
    rem_s  = rem_neg_q ? -raw_hi : raw_hi;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done      <= 1'b0;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
    end else begin
      state_q <= state_d;
      done    <= finish;
      if (accept) begin
        op_q      <= op_e'(op);
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        b_zero_q  <= (b == '0);
        a_q       <= a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else if (finish) begin
      case (op_q)
        OP_MUL:          result <= prod_s[WIDTH-1:0];
        OP_MULT,
        OP_MULTU:        {hi, lo} <= prod_s;
        OP_DIV, OP_DIVU: begin
          if (b_zero_q) begin
            lo <= '1;
            hi <= a_q;
          end else begin
            lo <= quo_s;
            hi <= rem_s;
          end
        end
        default: ;
      endcase
    end else if ((state_q == IDLE) && !done) begin
      if (hi_we) hi <= a;
      if (lo_we) lo <= a;
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) div0 <= 1'b0;
    else     div0 <= finish && op_is_div(op_q) && b_zero_q;
  end
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_BPC=2): latency, results,
// HI/LO writes, cancel and ignored-start behaviour.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel, hi_we, lo_we;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo, result;
  logic        busy, done;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div0;
`endif

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32), .MUL_BPC(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cancel(cancel),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .result(result)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .div0  (div0)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, then follow it to its done cycle. Returns while in the
  // done cycle. With poke set, a start and MTHI/MTLO are thrown in mid-op.
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input int n, input bit poke, input string tag);
    int cyc, busy_cyc;
    bit seen;
    start = 1'b1; op = o; a = aa; b = bb;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1; busy_cyc = 0; seen = 1'b0;
    while (!seen && cyc < n + 10) begin
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
      else begin
        if (poke && cyc == 3) begin
          start = 1'b1; op = 3'b001; hi_we = 1'b1; lo_we = 1'b1;
        end
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        cyc++;
      end
    end
    check({tag, " latency"}, 64'(cyc), 64'(n + 2));
    check({tag, " busy cycles"}, 64'(busy_cyc), 64'(n + 1));
  endtask

  initial begin
    logic [31:0] sv_hi, sv_lo, ra, rb, ehi, elo;
    logic [63:0] p;
    longint      sa, sb;
    int          si, sj;
    int          done_cnt;
    logic [2:0]  ro;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 3'b000; a = '0; b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset result", 64'(result), 64'd0);
`ifdef MULDIV_DIV0_FLAG_EN
    check("reset div0", 64'(div0), 64'd0);
`endif

    // MTLO in IDLE
    lo_we = 1'b1; a = 32'h1234_5678;
    tick();
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'h1234_5678);
    check("mtlo hi", 64'(hi), 64'd0);

    run_op(3'b000, -32'sd3, 32'd7, 16, 1'b0, "mult");
    check("mult hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo", 64'(lo), 64'hFFFF_FFEB);

    // MTHI in the done cycle must be ignored
    hi_we = 1'b1; a = 32'hAAAA_5555;
    tick();
    hi_we = 1'b0;
    check("mthi in done cycle", 64'(hi), 64'hFFFF_FFFF);
    hi_we = 1'b1; a = 32'h0BAD_F00D;
    tick();
    hi_we = 1'b0;
    check("mthi in idle", 64'(hi), 64'h0BAD_F00D);

    run_op(3'b010, -32'sd7, 32'd2, 32, 1'b0, "div");
    check("div lo", 64'(lo), 64'hFFFF_FFFD);
    check("div hi", 64'(hi), 64'hFFFF_FFFF);
`ifdef MULDIV_DIV0_FLAG_EN
    check("div div0", 64'(div0), 64'd0);
`endif

    run_op(3'b011, 32'd7, 32'd0, 32, 1'b0, "divu0");
    check("divu0 lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu0 hi", 64'(hi), 64'd7);
`ifdef MULDIV_DIV0_FLAG_EN
    check("divu0 div0", 64'(div0), 64'd1);
`endif

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b0, "div min");
    check("div min lo", 64'(lo), 64'h8000_0000);
    check("div min hi", 64'(hi), 64'd0);

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16, 1'b0, "multu max");
    check("multu max hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu max lo", 64'(lo), 64'h0000_0001);

    run_op(3'b100, 32'd1234, 32'd5678, 16, 1'b0, "mul");
    check("mul result", 64'(result), 64'h006A_E9BC);
    check("mul hi kept", 64'(hi), 64'hFFFF_FFFE);
    check("mul lo kept", 64'(lo), 64'h0000_0001);

    // Start and MTHI/MTLO while busy are ignored: 100/7 -> q=14 r=2
    run_op(3'b011, 32'd100, 32'd7, 32, 1'b1, "divu poke");
    check("divu poke lo", 64'(lo), 64'd14);
    check("divu poke hi", 64'(hi), 64'd2);
    tick();

    // Cancel at T+5 of a DIVU
    sv_hi = hi; sv_lo = lo;
    start = 1'b1; op = 3'b011; a = 32'd500; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("cancel busy before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy after", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("cancel no done", 64'(done_cnt), 64'd0);
    check("cancel hi kept", 64'(hi), 64'(sv_hi));
    check("cancel lo kept", 64'(lo), 64'(sv_lo));

    // Start with cancel in IDLE, and illegal op: nothing launches
    start = 1'b1; cancel = 1'b1; op = 3'b000;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start+cancel idle", 64'(busy), 64'd0);
    start = 1'b1; op = 3'b111;
    tick();
    start = 1'b0;
    check("illegal op busy", 64'(busy), 64'd0);
    tick();
    check("illegal op done", 64'(done), 64'd0);

    // Random signed/unsigned ops against an arithmetic reference
    for (int k = 0; k < 8; k++) begin
      ro = 3'(k % 4);
      ra = $urandom;
      rb = (k >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd5;
      case (ro)
        3'b000: begin
          sa = longint'($signed(ra)); sb = longint'($signed(rb));
          p = 64'(sa * sb); ehi = p[63:32]; elo = p[31:0];
        end
        3'b001: begin
          p = {32'd0, ra} * {32'd0, rb}; ehi = p[63:32]; elo = p[31:0];
        end
        3'b010: begin
          si = $signed(ra); sj = $signed(rb);
          elo = 32'(si / sj); ehi = 32'(si % sj);
        end
        default: begin
          elo = ra / rb; ehi = ra % rb;
        end
      endcase
      run_op(ro, ra, rb, (ro[1] ? 32 : 16), 1'b0, $sformatf("rand%0d", k));
      check($sformatf("rand%0d hi", k), 64'(hi), 64'(ehi));
      check($sformatf("rand%0d lo", k), 64'(lo), 64'(elo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
